// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_WIDTH_DEF = 4;

    // Iteration counter must hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fulladdertop.sv
// One-bit full adder cell, the building block of the ripple datapaths.
// Latency: combinational; backpressure: none.
module fulladdertop (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/nbit_subtractor.sv
// Ripple-borrow subtractor o_diff = i_a - i_b built as i_a + ~i_b + 1.
// Latency: combinational; backpressure: none.
module nbit_subtractor #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_no_borrow
);

    logic [WIDTH-1:0] w_b_n;
    logic [WIDTH:0]   w_carry;

    assign w_b_n      = ~i_b;
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        fulladdertop u_fa (
            .i_a    (i_a[g]),
            .i_b    (w_b_n[g]),
            .i_cin  (w_carry[g]),
            .o_sum  (o_diff[g]),
            .o_cout (w_carry[g+1])
        );
    end

    // A final carry out of the two's-complement add means a >= b.
    assign o_no_borrow = w_carry[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Latency WIDTH cycles (1 on divide-by-zero); start is ignored while busy.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam int RW = WIDTH + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_zero;
    logic               w_last;

    logic [RW-1:0]      r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_divisor;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dbz;

    logic [RW+WIDTH-1:0] w_cat;
    logic [RW+WIDTH-1:0] w_cat_shl;
    logic [RW-1:0]       w_shift;
    logic [RW-1:0]       w_trial;
    logic                w_no_borrow;
    logic [RW-1:0]       w_rem_nxt;
    logic [WIDTH-1:0]    w_q_nxt;

    assign w_zero = (r_divisor == '0);
    assign w_last = (r_cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_zero || w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shift {remainder, quotient} left; the dividend bit falls into the remainder.
    assign w_cat     = {r_rem, r_q};
    assign w_cat_shl = w_cat << 1;
    assign w_shift   = w_cat_shl[RW+WIDTH-1:WIDTH];

    nbit_subtractor #(
        .WIDTH (RW)
    ) u_sub (
        .i_a         (w_shift),
        .i_b         ({1'b0, r_divisor}),
        .o_diff      (w_trial),
        .o_no_borrow (w_no_borrow)
    );

    assign w_rem_nxt = w_no_borrow ? w_trial : w_shift;
    assign w_q_nxt   = w_cat_shl[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, w_no_borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_rem     <= '0;
            r_q       <= dividend;
            r_divisor <= divisor;
            r_cnt     <= CW'(WIDTH);
            r_dbz     <= 1'b0;
        end else if (r_state == RUN) begin
            if (w_zero) begin
                // r_q still holds the untouched dividend on this first RUN cycle.
                r_quotient  <= '1;
                r_remainder <= r_q;
                r_dbz       <= 1'b1;
                r_cnt       <= '0;
            end else begin
                r_rem <= w_rem_nxt;
                r_q   <= w_q_nxt;
                r_cnt <= r_cnt - CW'(1);
                if (w_last) begin
                    r_quotient  <= w_q_nxt;
                    r_remainder <= w_rem_nxt[WIDTH-1:0];
                end
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider at WIDTH=4.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_total = 0;
    int n_bad   = 0;

    logic [3:0] m_q = '0;
    logic [3:0] m_r = '0;

    seq_divider #(
        .WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one division (back-to-back if called in a done cycle) and waits for done.
    task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] eq, input logic [3:0] er,
                           input logic ez, input int elat, input string tag);
        int cyc;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        chk({tag, "_busy0"}, busy, 1);
        chk({tag, "_dbzclr"}, div_by_zero, 0);
        chk({tag, "_qhold"}, quotient, m_q);
        chk({tag, "_rhold"}, remainder, m_r);
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, cyc, elat);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, ez);
        m_q = eq;
        m_r = er;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        tick();

        run_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4, "d13_3");
        tick();
        chk("d13_3_donefall", done, 0);
        chk("d13_3_held", quotient, 4);

        run_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4, "d15_1");
        run_div(4'd5, 4'd7, 4'd0, 4'd5, 1'b0, 4, "b2b_5_7");
        tick();

        run_div(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1, "d9_0");
        run_div(4'd8, 4'd8, 4'd1, 4'd0, 1'b0, 4, "d8_8");
        tick();

        // start held with other operands while busy must not disturb 14/9.
        dividend = 4'd14;
        divisor  = 4'd9;
        start    = 1'b1;
        tick();
        dividend = 4'd2;
        divisor  = 4'd1;
        tick();
        tick();
        tick();
        start = 1'b0;
        chk("ign_busy_e3", busy, 1);
        chk("ign_done_e3", done, 0);
        tick();
        chk("ign_done_e4", done, 1);
        chk("ign_q", quotient, 1);
        chk("ign_r", remainder, 5);
        m_q = 4'd1;
        m_r = 4'd5;
        tick();
        chk("ign_idle_busy", busy, 0);
        chk("ign_idle_done", done, 0);

        dividend = 4'd11;
        divisor  = 4'd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_q", quotient, 0);
        chk("mrst_r", remainder, 0);
        chk("mrst_dbz", div_by_zero, 0);
        tick();
        chk("mrst_done_held", done, 0);
        rst = 1'b0;
        m_q = '0;
        m_r = '0;
        tick();
        chk("mrst_nodone", done, 0);
        chk("mrst_idle", busy, 0);
        run_div(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 4, "d11_2");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0] eq, er;
                if (b == 0) begin
                    eq = 4'd15;
                    er = 4'(a);
                    run_div(4'(a), 4'(b), eq, er, 1'b1, 1, "sw0");
                end else begin
                    eq = 4'(a / b);
                    er = 4'(a % b);
                    run_div(4'(a), 4'(b), eq, er, 1'b0, 4, "sw");
                    chk("sw_ident", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                    chk("sw_rlt", 32'(32'(remainder) < 32'(b)), 1);
                end
            end
        end
        tick();
        chk("end_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
